// File: rtl/collision_event_scheduler_pkg.sv
// Shared types for the pinball collision event path: event source indices,
// scheduler FSM states and small bit-vector helpers.
package pinball_pkg;

  localparam int NUM_EVT = 6;

  typedef enum logic [2:0] {
    EVT_BOTTOM   = 3'd0,
    EVT_OBSTACLE = 3'd1,
    EVT_FLIPPER  = 3'd2,
    EVT_TOP      = 3'd3,
    EVT_LEFT     = 3'd4,
    EVT_RIGHT    = 3'd5
  } evt_id_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } sched_state_t;

  // Lowest set index wins: bottom border (life lost) outranks everything.
  function automatic evt_id_t lowest_set(input logic [NUM_EVT-1:0] v);
    evt_id_t r;
    r = EVT_BOTTOM;
    for (int i = NUM_EVT - 1; i >= 0; i--) begin
      if (v[i]) r = evt_id_t'(3'(i));
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount(input logic [NUM_EVT-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_EVT; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/collision_event_scheduler_if.sv
// Event delivery bus between the scheduler (master) and the game controller
// (slave): valid/ready handshake plus pending/statistics status.
interface collision_event_scheduler_if;
  import pinball_pkg::*;

  logic               evt_valid;
  logic [2:0]         evt_id;
  logic               evt_ready;
  logic [NUM_EVT-1:0] evt_pending;
  logic [7:0]         drop_count;

  modport master (
    output evt_valid, evt_id, evt_pending, drop_count,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_id, evt_pending, drop_count,
    output evt_ready
  );
endinterface

// File: rtl/collision_event_scheduler_cooldown_counter.sv
// Per-source cooldown: 4-bit counter with clear, load and a decrement that
// fires once per frame and stops at zero. Clear beats load beats decrement.
module cooldown_counter (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count
);

  // Counter register with clear > load > frame decrement priority.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/collision_event_scheduler.sv
// Collision event scheduler: latches collision pulses during a scan, commits
// them at start of frame and delivers them one at a time, lowest index first.
// A per-source cooldown blocks re-capture while the ball still overlaps.
// Optional feature macro: COLL_EVT_STATS_EN builds the saturating drop_count
// statistic; without it drop_count is constant zero.
module collision_event_scheduler
  import pinball_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        pause,
  input  logic                        reset_level,
  input  logic [NUM_EVT-1:0]          coll_in,
  collision_event_scheduler_if.master evt
);

  logic [NUM_EVT-1:0] hit_lat;
  logic [NUM_EVT-1:0] pend;
  logic [NUM_EVT-1:0] cd_zero;
  logic [NUM_EVT-1:0] capture;
  logic [NUM_EVT-1:0] accept_mask;
  logic [NUM_EVT-1:0] pend_kept;
  logic [3:0]         cooldown [NUM_EVT];
  logic [2:0]         evt_id_q;
  logic               valid;
  logic               accept;
  logic               offer_start;
  sched_state_t       state;
  sched_state_t       state_next;

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_cd
    cooldown_counter u_cd (
      .clk      (clk),
      .resetN   (resetN),
      .clear    (reset_level),
      .load     (accept_mask[g]),
      .load_val (4'(COOLDOWN_FRAMES)),
      .dec      (startOfFrame),
      .count    (cooldown[g])
    );
    assign cd_zero[g] = (cooldown[g] == 4'd0);
  end

  assign capture     = pause ? '0 : (coll_in & cd_zero);
  assign accept      = valid & evt.evt_ready;
  assign accept_mask = accept ? ({{(NUM_EVT-1){1'b0}}, 1'b1} << evt_id_q) : '0;
  assign pend_kept   = pend & ~accept_mask;

  // Per-frame hit latch: sticky within a frame, restarts at start of frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)            hit_lat <= '0;
    else if (reset_level)   hit_lat <= '0;
    else if (startOfFrame)  hit_lat <= capture;
    else                    hit_lat <= hit_lat | capture;
  end

  // Committed events: accepted bit drops out, frame commit merges the latch.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)            pend <= '0;
    else if (reset_level)   pend <= '0;
    else if (startOfFrame)  pend <= pend_kept | hit_lat;
    else                    pend <= pend_kept;
  end

  // Delivery FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_next;
  end

  // Delivery FSM next state; every accept returns through IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if ((pend != '0) && !pause) state_next = S_OFFER;
      S_OFFER: if (evt.evt_ready)          state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (reset_level) state_next = S_IDLE;
  end

  // Delivery FSM outputs.
  always_comb begin
    valid       = (state == S_OFFER);
    offer_start = (state == S_IDLE) && (state_next == S_OFFER);
  end

  // Offered id is captured once on entry to OFFER and held until accepted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)          evt_id_q <= '0;
    else if (offer_start) evt_id_q <= lowest_set(pend);
  end

  assign evt.evt_valid   = valid;
  assign evt.evt_id      = evt_id_q;
  assign evt.evt_pending = pend;

`ifdef COLL_EVT_STATS_EN
  logic [NUM_EVT-1:0] coalesced;
  logic [7:0]         drop_q;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b00000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // A hit whose source is still pending at commit merges into that event.
  assign coalesced = (startOfFrame && !reset_level) ? (pend_kept & hit_lat) : '0;

  // Saturating count of coalesced hits; survives reset_level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)         drop_q <= '0;
    else if (|coalesced) drop_q <= sat_add8(drop_q, popcount(coalesced));
  end

  assign evt.drop_count = drop_q;
`else
  assign evt.drop_count = '0;
`endif

endmodule
